// File: rtl/ws2812_driver.sv
// Purpose: serialises one GRB colour into the WS2812 single-wire protocol for a chain of LEDs, then a low latch gap.
// Latency: led_out rises on the same edge that captures the levels; bit k starts k*T_BIT cycles later.
// Backpressure: none; frames start only from IDLE while enable is high, and a started frame always completes.
// Ports: clk, reset (async active-low), enable, level_r/g/b [7:0] in; led_out, busy, frame_done (1-cycle pulse) out.
module ws2812_driver #(
  parameter int T0H          = 4,
  parameter int T1H          = 8,
  parameter int T_BIT        = 13,
  parameter int RESET_CYCLES = 600,
  parameter int NUM_LEDS     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] level_r,
  input  logic [7:0] level_g,
  input  logic [7:0] level_b,
  output logic       led_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int CMAX = (T_BIT > RESET_CYCLES) ? T_BIT : RESET_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int LW   = $clog2(NUM_LEDS + 1);

  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [CW-1:0] CYC_BITM1 = CW'(T_BIT - 1);
  localparam logic [CW-1:0] CYC_GAPM1 = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] CYC_T0H   = CW'(T0H);
  localparam logic [CW-1:0] CYC_T1H   = CW'(T1H);
  localparam logic [LW-1:0] LED_ONE   = LW'(1);
  localparam logic [LW-1:0] LED_LASTM = LW'(NUM_LEDS - 1);

  if (!(T0H >= 1 && T0H < T1H && T1H < T_BIT && RESET_CYCLES >= 1 && NUM_LEDS >= 1)) begin : g_param_check
    $error("ws2812_driver: illegal timing parameters");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state_q, state_d;
  logic [23:0]    colour_q, colour_d;
  logic [23:0]    shift_q, shift_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [4:0]     bit_q, bit_d;
  logic [LW-1:0]  led_cnt_q, led_cnt_d;
  logic           led_q, led_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      colour_q  <= '0;
      shift_q   <= '0;
      cyc_q     <= '0;
      bit_q     <= '0;
      led_cnt_q <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      colour_q  <= colour_d;
      shift_q   <= shift_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      led_cnt_q <= led_cnt_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // led_out is registered, so each branch computes the level for the cycle
  // that the *next* counter/shift values describe.
  always_comb begin
    state_d   = state_q;
    colour_d  = colour_q;
    shift_d   = shift_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    led_cnt_d = led_cnt_q;
    led_d     = led_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        led_d  = 1'b0;
        busy_d = 1'b0;
        if (enable) begin
          colour_d  = {level_g, level_r, level_b};
          shift_d   = {level_g, level_r, level_b};
          cyc_d     = '0;
          bit_d     = '0;
          led_cnt_d = '0;
          led_d     = 1'b1;
          busy_d    = 1'b1;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (cyc_q == CYC_BITM1) begin
          cyc_d = '0;
          if (bit_q == 5'd23) begin
            if (led_cnt_q < LED_LASTM) begin
              // Later LEDs repeat the frame's captured colour, not the live inputs.
              shift_d   = colour_q;
              led_cnt_d = led_cnt_q + LED_ONE;
              bit_d     = '0;
              led_d     = 1'b1;
            end else begin
              led_d = 1'b0;
              // cyc counts elapsed low cycles including the current one, so
              // the gap is exactly RESET_CYCLES long counting the frame_done cycle.
              if (RESET_CYCLES == 1) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                state_d = GAP;
                cyc_d   = CYC_ONE;
              end
            end
          end else begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            led_d   = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
          led_d = ((cyc_q + CYC_ONE) < (shift_q[23] ? CYC_T1H : CYC_T0H));
        end
      end

      GAP: begin
        led_d = 1'b0;
        if (cyc_q == CYC_GAPM1) begin
          state_d = IDLE;
          cyc_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        led_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign led_out    = led_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_driver.sv
module tb_ws2812_driver;

  localparam int MAXW = 4096;
  localparam int TB   = 13;
  localparam int GAPC = 600;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en1 = 1'b0;
  logic       en3 = 1'b0;
  logic [7:0] lg = '0, lr = '0, lb = '0;
  logic       led1, busy1, done1, led3, busy3, done3;
  logic       sel = 1'b0;
  logic       led_s, busy_s, done_s;

  assign led_s  = sel ? led3  : led1;
  assign busy_s = sel ? busy3 : busy1;
  assign done_s = sel ? done3 : done1;

  always #5 clk = ~clk;

  ws2812_driver dut1 (
    .clk(clk), .reset(reset), .enable(en1),
    .level_r(lr), .level_g(lg), .level_b(lb),
    .led_out(led1), .busy(busy1), .frame_done(done1)
  );

  ws2812_driver #(.NUM_LEDS(3)) dut3 (
    .clk(clk), .reset(reset), .enable(en3),
    .level_r(lr), .level_g(lg), .level_b(lb),
    .led_out(led3), .busy(busy3), .frame_done(done3)
  );

  typedef struct {
    logic [7:0]  g;
    logic [7:0]  r;
    logic [7:0]  b;
    logic [23:0] exp_grb;
  } vec_t;

  vec_t vecs[5];

  logic wl[MAXW];
  logic wb[MAXW];
  logic wd[MAXW];
  int   done_at[4];
  int   ndone;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drop_en();
    if (sel) en3 = 1'b0;
    else     en1 = 1'b0;
  endtask

  // Caller raises enable at a negedge; the following posedge is E0 and
  // sample index i is taken on the negedge after edge E0+i.
  task automatic record(input int nframes, input bit hold, input int chg_idx,
                        input logic [7:0] ng, input logic [7:0] nr, input logic [7:0] nb);
    int last;
    last  = -1;
    ndone = 0;
    for (int j = 0; j < 4; j++) done_at[j] = -1;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      wl[i] = led_s;
      wb[i] = busy_s;
      wd[i] = done_s;
      if (i == chg_idx) begin
        lg = ng; lr = nr; lb = nb;
      end
      if (!hold && i == 0) drop_en();
      if (done_s) begin
        if (ndone < 4) done_at[ndone] = i;
        ndone++;
        if (ndone == nframes) begin
          drop_en();
          last = i;
        end
      end
      if (last >= 0 && i == last + 2) break;
    end
    check("record_complete", int'(last >= 0), 1);
  endtask

  task automatic check_frame(input int nleds, input logic [23:0] w, input int base,
                             input int fidx, input string tag);
    int nbits, gstart, edone, ones, hi, idx, act, expw;
    bit well;
    nbits  = 24 * nleds;
    gstart = base + nbits * TB;
    edone  = gstart + GAPC - 1;
    for (int k = 0; k < nbits; k++) begin
      hi   = 0;
      well = 1'b1;
      for (int c = 0; c < TB; c++) begin
        idx = base + k * TB + c;
        if (wl[idx]) begin
          if (c != hi) well = 1'b0;
          hi++;
        end
      end
      act  = well ? hi : -1;
      expw = w[23 - (k % 24)] ? 8 : 4;
      check($sformatf("%s bit%0d high_width", tag, k), act, expw);
    end
    check($sformatf("%s frame_done_index", tag), done_at[fidx], edone);
    ones = 0;
    for (int i = gstart; i <= edone; i++) if (wl[i]) ones++;
    check($sformatf("%s gap_high_cycles", tag), ones, 0);
    check($sformatf("%s busy_before_done", tag), int'(wb[edone - 1]), 1);
    check($sformatf("%s busy_at_done", tag), int'(wb[edone]), 0);
    check($sformatf("%s done_pulse_width", tag), int'(wd[edone - 1]) + int'(wd[edone + 1]), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int di;

    vecs[0] = '{g: 8'hA5, r: 8'h00, b: 8'hFF, exp_grb: 24'hA500FF};
    vecs[1] = '{g: 8'h00, r: 8'hFF, b: 8'h00, exp_grb: 24'h00FF00};
    vecs[2] = '{g: 8'h80, r: 8'h01, b: 8'h5A, exp_grb: 24'h80015A};
    vecs[3] = '{g: 8'hFF, r: 8'hFF, b: 8'hFF, exp_grb: 24'hFFFFFF};
    vecs[4] = '{g: 8'h00, r: 8'h00, b: 8'h00, exp_grb: 24'h000000};

    // Reset held with enable high and random levels: outputs stay quiet.
    en1 = 1'b1;
    en3 = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lg = 8'($urandom_range(0, 255));
      lr = 8'($urandom_range(0, 255));
      lb = 8'($urandom_range(0, 255));
      bad += int'(led1) + int'(busy1) + int'(done1) + int'(led3) + int'(busy3) + int'(done3);
    end
    check("reset_outputs_quiet", bad, 0);

    // Release reset with enable still high: first frame captures vector 0.
    @(negedge clk);
    en3 = 1'b0;
    lg = vecs[0].g; lr = vecs[0].r; lb = vecs[0].b;
    reset = 1'b1;
    sel = 1'b0;

    for (int v = 0; v < 5; v++) begin
      if (v > 0) begin
        @(negedge clk);
        lg = vecs[v].g; lr = vecs[v].r; lb = vecs[v].b;
        en1 = 1'b1;
      end
      record(1, 1'b0, -1, 8'h00, 8'h00, 8'h00);
      if (v == 0) check("first_edge_rise", int'(wl[0]), 1);
      check_frame(1, vecs[v].exp_grb, 0, 0, $sformatf("vec%0d", v));
      di = 24 * TB + GAPC - 1;
      check($sformatf("vec%0d idle_after", v),
            int'(wl[di + 1]) + int'(wl[di + 2]) + int'(wb[di + 1]) + int'(wb[di + 2]), 0);
    end

    // Three back-to-back frames with enable held high.
    @(negedge clk);
    lg = 8'h5A; lr = 8'hC3; lb = 8'h81;
    en1 = 1'b1;
    record(3, 1'b1, -1, 8'h00, 8'h00, 8'h00);
    check("hold3 done_count", ndone, 3);
    for (int j = 0; j < 3; j++) begin
      check_frame(1, 24'h5AC381, j * (24 * TB + GAPC), j, $sformatf("hold3 f%0d", j));
      if (j < 2) check($sformatf("hold3 rise_after_done%0d", j), int'(wl[done_at[j] + 1]), 1);
    end
    check("hold3 idle_after_last", int'(wl[done_at[2] + 1]) + int'(wb[done_at[2] + 2]), 0);

    // Three-LED chain: levels change mid-frame and only the next frame sees them.
    sel = 1'b1;
    @(negedge clk);
    lg = 8'h3C; lr = 8'hC3; lb = 8'h0F;
    en3 = 1'b1;
    record(1, 1'b0, 100, 8'h11, 8'h22, 8'h33);
    check_frame(3, 24'h3CC30F, 0, 0, "chain3 f0");
    @(negedge clk);
    en3 = 1'b1;
    record(1, 1'b0, -1, 8'h00, 8'h00, 8'h00);
    check_frame(3, 24'h112233, 0, 0, "chain3 f1");

    // Reset during the high phase of bit 10 (a 0 bit, indices 130..133).
    sel = 1'b0;
    @(negedge clk);
    lg = 8'hA5; lr = 8'h00; lb = 8'hFF;
    en1 = 1'b1;
    for (int i = 0; i <= 131; i++) begin
      @(negedge clk);
      if (i == 0) en1 = 1'b0;
    end
    check("midframe bit10_high", int'(led1), 1);
    reset = 1'b0;
    #1;
    check("midframe led_async_clear", int'(led1), 0);
    check("midframe busy_async_clear", int'(busy1), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bad += int'(led1) + int'(busy1) + int'(done1);
    end
    check("post_reset_stays_idle", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ws2812_driver.md
# ws2812_driver

Serialises three 8-bit colour levels into the single-wire WS2812/NeoPixel protocol. It is the downstream sink for the three encoder values, used as an alternative to the per-channel PWM outputs, so one data pin drives a chain of smart LEDs. Colour is sampled once per frame. The same colour is sent to every LED in the chain, followed by a low latch gap.

## Interface
Parameters:
- T0H, 4: high cycles for a 0 bit (400 ns at 10 MHz)
- T1H, 8: high cycles for a 1 bit (800 ns at 10 MHz)
- T_BIT, 13: total cycles per bit
- RESET_CYCLES, 600: latch-gap low cycles (60 µs at 10 MHz)
- NUM_LEDS, 1: LEDs in chain, ≥1

Ports:
- clk  input  1  single system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- enable  input  1  level; frames start only while high
- level_r  input  8  red level
- level_g  input  8  green level
- level_b  input  8  blue level
- led_out  output  1  registered serial data to LED chain
- busy  output  1  high while a frame (bits + gap) is in progress
- frame_done  output  1  one-cycle pulse at end of latch gap

## Operation
- Reset values: led_out=0, busy=0, frame_done=0, state=IDLE, all counters 0.
- Legality: 1 ≤ T0H < T1H < T_BIT, RESET_CYCLES ≥ 1. Elaboration-time check.
- FSM has three states: IDLE, SEND and GAP.
- IDLE, with enable=1 at an edge:
  - Latch {level_g, level_r, level_b} into a 24-bit colour register and a 24-bit shift register (GRB order, MSB first).
  - Clear the bit, LED and cycle counters.
  - Set led_out=1, busy=1, state→SEND.
- IDLE, with enable=0: hold. led_out=0, busy=0.
- SEND, per bit, with the cycle counter c running 0..T_BIT-1:
  - led_out=1 for c < TxH, else 0. TxH is T1H if shift[23]=1, else T0H.
  - At c=T_BIT-1, the shift register shifts left by 1 and c wraps to 0.
  - The next bit's high phase begins on that edge, so there are no dead cycles between bits.
- SEND, after bit 23 of an LED:
  - If LED count < NUM_LEDS-1: reload the shift register from the colour register (not from the live inputs) and increment the LED count.
  - Otherwise: state→GAP, with led_out=0.
- GAP: led_out=0 for RESET_CYCLES cycles. On the last gap edge: frame_done=1 for one cycle, busy=0, state→IDLE.
- Live level inputs are ignored between captures. Changes mid-frame affect only the next frame.
- enable falling mid-frame does not abort; the frame and gap complete.
- Counter widths: cycle counter ceil(log2(max(T_BIT, RESET_CYCLES))), bit counter 5 bits, LED counter ceil(log2(NUM_LEDS+1)). There is no wrap other than the defined ones.

## Timing
- Edge E0 is the IDLE edge with enable=1. Capture happens and led_out rises on E0. There is no extra latency.
- Bit k, counting from k=0 across the whole frame, starts at E0 + k·T_BIT.
- The gap starts at E0 + 24·NUM_LEDS·T_BIT.
- frame_done is high in the cycle after edge E0 + 24·NUM_LEDS·T_BIT + RESET_CYCLES − 1.
- busy falls with frame_done.
- With enable held high, the next capture is 1 cycle after frame_done. The next led_out rise follows the frame_done cycle by 1 cycle.
- Reset low mid-frame forces led_out=0 and busy=0 asynchronously. After release the block is in IDLE and needs a fresh enable edge sample.

## Test plan
- Reset held low with enable=1 and random levels -> led_out, busy and frame_done stay 0. After release, the first rising edge of led_out is on the first clock edge.
- Defaults, g=0xA5, r=0x00, b=0xFF, single frame:
  - High widths are 8,4,8,4,4,8,4,8, then 4×8, then 8×8.
  - Each bit is 13 cycles.
  - frame_done comes 912 cycles after capture (24·13 + 600).
- NUM_LEDS=3, levels changed at cycle 100 after capture:
  - 72 bits are sent, all three LEDs carry the originally captured pattern.
  - frame_done at 1536 (72·13 + 600).
  - The next frame carries the new levels.
- enable held high for 3 frames -> exactly 3 frame_done pulses, each 1 cycle wide. Each next led_out rise follows a frame_done pulse by 1 cycle. led_out is low for all 600 gap cycles.
- Reset asserted during the high phase of bit 10 -> led_out drops before the next clock edge. After release with enable=0, led_out stays 0 and busy stays 0.
- enable pulsed for 1 cycle, then dropped mid-frame -> the full frame plus gap completes, one frame_done pulse occurs, then the block stays idle.
